bg_vram_writer: RTL and testbench

//  Write-side counterpart to the background pixel fetch path: fills BG VRAM with packed palette indices.

---
 rtl/bg_vram_pkg.sv | 38 +++
 rtl/bg_vram_writer_if.sv | 40 ++++
 rtl/bg_pixel_packer.sv | 79 +++++++
 rtl/bg_vram_writer.sv | 124 ++++++++++++
 tb/tb_bg_vram_writer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/bg_vram_pkg.sv
// ---------------------------------------------------------------------------
// bg_vram_pkg
//   Shared constants for the background VRAM path. Both the write-side packer
//   and the scan-out reader import this package, so the pixel packing order
//   inside a VRAM word is defined in exactly one place.
//
//   Packing: the 1st pixel of a word lives in the top field [8:6], the 2nd in
//   [5:3] and the 3rd in [2:0]. slot_lsb() returns the LSB of a slot's field.
// ---------------------------------------------------------------------------
package bg_vram_pkg;

  localparam int ADDR_W    = 11;                 // VRAM word address width
  localparam int PIX_W     = 3;                  // bits per palette index
  localparam int PIX_PER_W = 3;                  // pixels per VRAM word
  localparam int WORD_W    = PIX_W * PIX_PER_W;  // VRAM word width (9)
  localparam int SLOT_W    = 2;                  // slot counter width (0..2)

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PIX_PER_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  // Palette indices with a fixed meaning in the background.
  localparam logic [PIX_W-1:0] SKY_IDX    = 3'd5;
  localparam logic [PIX_W-1:0] GROUND_IDX = 3'd2;
  // A partial word on flush is padded with sky so stray pixels are invisible.
  localparam logic [PIX_W-1:0] PAD_IDX    = SKY_IDX;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2
  } wr_state_e;

  // LSB position of the field holding pixel number 'slot' (0 = first pixel).
  function automatic int slot_lsb(input int slot);
    return (PIX_PER_W - 1 - slot) * PIX_W;
  endfunction

endpackage

// File: rtl/bg_vram_writer_if.sv
// ---------------------------------------------------------------------------
// bg_vram_writer_if
//   Bundles the loader-facing pixel stream and the BG VRAM write port of
//   bg_vram_writer.
//     master : loader / CPU side (drives start, pixels, flush; sees writes)
//     slave  : bg_vram_writer itself
//   Signals:
//     start_valid/start_addr  begin a fill run at a word address
//     px_valid/px_idx/px_ready pixel stream handshake
//     flush                    end the run, pad and write a partial word
//     busy                     run in progress
//     vram_addr/vram_din/vram_we  single-cycle VRAM write
//     wrapped                  pulse on a write to the last VRAM address
// ---------------------------------------------------------------------------
interface bg_vram_writer_if;
  import bg_vram_pkg::*;

  logic                start_valid;
  logic [ADDR_W-1:0]   start_addr;
  logic                px_valid;
  logic [PIX_W-1:0]    px_idx;
  logic                px_ready;
  logic                flush;
  logic                busy;
  logic [ADDR_W-1:0]   vram_addr;
  logic [WORD_W-1:0]   vram_din;
  logic                vram_we;
  logic                wrapped;

  modport master (
    output start_valid, start_addr, px_valid, px_idx, flush,
    input  px_ready, busy, vram_addr, vram_din, vram_we, wrapped
  );

  modport slave (
    input  start_valid, start_addr, px_valid, px_idx, flush,
    output px_ready, busy, vram_addr, vram_din, vram_we, wrapped
  );

endinterface

// File: rtl/bg_pixel_packer.sv
// ---------------------------------------------------------------------------
// bg_pixel_packer
//   Collects palette indices into VRAM words. Holds the slot counter and the
//   partially assembled word; reports combinationally when a word must be
//   written this cycle (third pixel accepted, or flush with partial data) and
//   presents that word with the current pixel merged in and, on flush, the
//   empty slots filled with PAD_IDX.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     clear_i       drop any partial word (start of a new run)
//     accept_i      px_i is accepted this cycle
//     px_i          palette index
//     flush_i       flush request (already qualified by the caller's state)
//     emit_o        a word must be written this cycle
//     pad_o         the emitted word is a padded partial word
//     word_o        word to write (valid when emit_o)
// ---------------------------------------------------------------------------
module bg_pixel_packer
  import bg_vram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [PIX_W-1:0]  px_i,
  input  logic              flush_i,
  output logic              emit_o,
  output logic              pad_o,
  output logic [WORD_W-1:0] word_o
);

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] merged;
  logic [SLOT_W-1:0] fill_cnt;   // pixels in the word including this cycle's
  logic              full;
  logic              partial;

  assign fill_cnt = slot_q + SLOT_W'(accept_i);
  assign full     = accept_i && (slot_q == LAST_SLOT);
  // A flush that lands exactly on a completed word is an ordinary full write.
  assign partial  = flush_i && !full && (fill_cnt != '0);
  assign emit_o   = full || partial;
  assign pad_o    = partial;

  generate
    for (genvar gi = 0; gi < PIX_PER_W; gi++) begin : g_slot
      localparam int Lsb = slot_lsb(gi);
      assign merged[Lsb +: PIX_W] = (accept_i && (slot_q == SLOT_W'(gi)))
                                    ? px_i : word_q[Lsb +: PIX_W];
      // Slots at or beyond the fill count never received a pixel.
      assign word_o[Lsb +: PIX_W] = (partial && (fill_cnt <= SLOT_W'(gi)))
                                    ? PAD_IDX : merged[Lsb +: PIX_W];
    end
  endgenerate

  always_comb begin
    slot_d = slot_q;
    word_d = word_q;
    if (clear_i || emit_o) begin
      slot_d = '0;
      word_d = '0;
    end else if (accept_i) begin
      slot_d = slot_q + 1'b1;
      word_d = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      word_q <= '0;
    end else begin
      slot_q <= slot_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/bg_vram_writer.sv
// ---------------------------------------------------------------------------
// bg_vram_writer
//   Fills BG VRAM with packed palette indices. A run starts at start_addr;
//   every three accepted pixels produce one 9-bit word written one cycle
//   after the third accept at an auto-incrementing address. flush ends the
//   run, writing any partial word padded with PAD_IDX.
//   Ports:
//     clk   system clock (posedge)
//     rst   synchronous active-high reset; a partial word is discarded
//     bus   bg_vram_writer_if.slave: pixel stream, control and write port
// ---------------------------------------------------------------------------
module bg_vram_writer
  import bg_vram_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  bg_vram_writer_if.slave  bus
);

  wr_state_e         state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic              px_ready_q;
  logic              busy_q;
  logic              vram_we_q;
  logic              wrapped_q;
  logic [ADDR_W-1:0] vram_addr_q;
  logic [WORD_W-1:0] vram_din_q;

  logic              in_fill;
  logic              start_req;
  logic              accept;
  logic              flush_req;
  logic              emit;
  logic              pad;
  logic [WORD_W-1:0] emit_word;

  assign in_fill   = (state_q == ST_FILL);
  assign start_req = (state_q == ST_IDLE) && bus.start_valid;
  // px_ready is high for the whole of FILL, so FILL alone qualifies accepts.
  assign accept    = in_fill && bus.px_valid;
  assign flush_req = in_fill && bus.flush;
  assign ptr_d     = ptr_q + ADDR_W'(1);

  bg_pixel_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (start_req),
    .accept_i (accept),
    .px_i     (bus.px_idx),
    .flush_i  (flush_req),
    .emit_o   (emit),
    .pad_o    (pad),
    .word_o   (emit_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      px_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      vram_we_q   <= 1'b0;
      wrapped_q   <= 1'b0;
      vram_addr_q <= '0;
      vram_din_q  <= '0;
    end else begin
      // Strobes default low; address and data hold their last value.
      vram_we_q <= 1'b0;
      wrapped_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (bus.start_valid) begin
            ptr_q      <= bus.start_addr;
            state_q    <= ST_FILL;
            px_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        ST_FILL: begin
          // Covers both a completed triple and a padded flush word.
          if (emit) begin
            vram_we_q   <= 1'b1;
            vram_addr_q <= ptr_q;
            vram_din_q  <= emit_word;
            wrapped_q   <= (ptr_q == ADDR_MAX);
            ptr_q       <= ptr_d;
          end
          if (flush_req) begin
            px_ready_q <= 1'b0;
            if (pad) begin
              // The padded write is on the bus during FLUSH, busy still high.
              state_q <= ST_FLUSH;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        ST_FLUSH: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q    <= ST_IDLE;
          px_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.px_ready  = px_ready_q;
  assign bus.busy      = busy_q;
  assign bus.vram_we   = vram_we_q;
  assign bus.wrapped   = wrapped_q;
  assign bus.vram_addr = vram_addr_q;
  assign bus.vram_din  = vram_din_q;

endmodule

// File: tb/tb_bg_vram_writer.sv
// ---------------------------------------------------------------------------
// tb_bg_vram_writer
//   Directed scenarios followed by a randomized run. A reference model built
//   on a pixel queue predicts every output after each clock edge.
// ---------------------------------------------------------------------------
module tb_bg_vram_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bg_vram_writer_if bus ();

  bg_vram_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  localparam int M_IDLE  = 0;
  localparam int M_FILL  = 1;
  localparam int M_FLUSH = 2;
  int m_mode = M_IDLE;
  int m_ptr  = 0;
  int m_pend[$];
  int exp_ready = 0, exp_busy = 0, exp_we = 0, exp_wrap = 0;
  int exp_addr = 0, exp_din = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_emit();
    exp_we   = 1;
    exp_addr = m_ptr;
    exp_din  = m_pend[0] * 64 + m_pend[1] * 8 + m_pend[2];
    exp_wrap = (m_ptr == 2047) ? 1 : 0;
    m_ptr    = (m_ptr + 1) % 2048;
    m_pend.delete();
  endtask

  task automatic m_step(input bit r, input bit sv, input int sa,
                        input bit pv, input int pi, input bit fl);
    if (r) begin
      m_mode = M_IDLE; m_ptr = 0; m_pend.delete();
      exp_ready = 0; exp_busy = 0; exp_we = 0; exp_wrap = 0;
      exp_addr = 0; exp_din = 0;
      return;
    end
    exp_we = 0;
    exp_wrap = 0;
    case (m_mode)
      M_IDLE: if (sv) begin
        m_ptr = sa; m_pend.delete();
        m_mode = M_FILL; exp_ready = 1; exp_busy = 1;
      end
      M_FILL: begin
        if (pv) begin
          m_pend.push_back(pi);
          if (m_pend.size() == 3) m_emit();
        end
        if (fl) begin
          exp_ready = 0;
          if (m_pend.size() > 0) begin
            while (m_pend.size() < 3) m_pend.push_back(5);
            m_emit();
            m_mode = M_FLUSH;
          end else begin
            m_mode = M_IDLE;
            exp_busy = 0;
          end
        end
      end
      default: begin
        m_mode = M_IDLE;
        exp_busy = 0;
      end
    endcase
  endtask

  // One clock: drive inputs, let the edge happen, then compare every output.
  task automatic cyc(input bit r, input bit sv, input int sa,
                     input bit pv, input int pi, input bit fl);
    rst             = r;
    bus.start_valid = sv;
    bus.start_addr  = sa[10:0];
    bus.px_valid    = pv;
    bus.px_idx      = pi[2:0];
    bus.flush       = fl;
    @(posedge clk);
    m_step(r, sv, sa, pv, pi, fl);
    #1;
    check("px_ready",  {31'd0, bus.px_ready}, exp_ready);
    check("busy",      {31'd0, bus.busy},     exp_busy);
    check("vram_we",   {31'd0, bus.vram_we},  exp_we);
    check("wrapped",   {31'd0, bus.wrapped},  exp_wrap);
    check("vram_addr", {21'd0, bus.vram_addr}, exp_addr);
    check("vram_din",  {23'd0, bus.vram_din}, exp_din);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic px(input int v);
    cyc(0, 0, 0, 1, v, 0);
  endtask

  task automatic start(input int a);
    cyc(0, 1, a, 0, 0, 0);
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.start_addr  = '0;
    bus.px_valid    = 1'b0;
    bus.px_idx      = '0;
    bus.flush       = 1'b0;

    // T1: reset, then one full word
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    start(12'h010);
    px(1); px(2); px(3);
    check("t1_we",   {31'd0, bus.vram_we}, 32'd1);
    check("t1_addr", {21'd0, bus.vram_addr}, 32'h010);
    check("t1_din",  {23'd0, bus.vram_din}, 32'b001_010_011);
    idle(1);

    // Flush at slot 0 returns to IDLE with no write
    cyc(0, 0, 0, 0, 0, 1);
    check("t5_noflushwr", {31'd0, bus.vram_we}, 32'd0);

    // T2: six back-to-back pixels
    start(12'h010);
    for (int i = 0; i < 6; i++) px(i);
    check("t2_addr2", {21'd0, bus.vram_addr}, 32'h011);
    cyc(0, 0, 0, 0, 0, 1);

    // T3: wrap from 0x7FF to 0x000
    start(12'h7FF);
    px(1); px(1); px(1);
    check("t3_wrap", {31'd0, bus.wrapped}, 32'd1);
    px(2); px(2); px(2);
    check("t3_addr0", {21'd0, bus.vram_addr}, 32'h000);
    cyc(0, 0, 0, 0, 0, 1);

    // T4: partial word padded on flush
    start(12'h020);
    px(7); px(4);
    cyc(0, 0, 0, 0, 0, 1);
    check("t4_din", {23'd0, bus.vram_din}, 32'b111_100_101);
    idle(1);
    check("t4_busy", {31'd0, bus.busy}, 32'd0);

    // T5: flush together with the completing pixel
    start(12'h030);
    px(1); px(2);
    cyc(0, 0, 0, 1, 3, 1);
    check("t5_din", {23'd0, bus.vram_din}, 32'b001_010_011);
    idle(2);
    cyc(0, 0, 0, 0, 0, 1);   // flush in IDLE is ignored

    // T6: reset mid-run discards the partial word
    start(12'h040);
    px(1); px(2);
    cyc(1, 0, 0, 0, 0, 0);
    idle(1);
    start(12'h000);
    px(6); px(6); px(6);
    check("t6_din", {23'd0, bus.vram_din}, 32'b110_110_110);
    cyc(0, 0, 0, 0, 0, 1);

    // Randomized run
    for (int i = 0; i < 4000; i++) begin
      bit r, sv, pv, fl;
      int sa;
      r  = ($urandom_range(0, 299) == 0);
      sv = ($urandom_range(0, 7) == 0);
      sa = ($urandom_range(0, 3) == 0) ? $urandom_range(2045, 2047)
                                       : $urandom_range(0, 2047);
      pv = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 24) == 0);
      cyc(r, sv, sa, pv, $urandom_range(0, 7), fl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
